// File: rtl/ifetch_req_ctrl.sv
// ifetch_req_ctrl: in-order fetch request/return tracker with flush cancel; define IFETCH_DATA_BYPASS_EN for same-cycle data_ok bypass
module ifetch_req_ctrl #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int OST_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_valid_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    output logic                  pc_ready_o,
    input  logic                  flush_i,
    output logic                  inst_sram_req_o,
    output logic [PC_WIDTH-1:0]   inst_sram_addr_o,
    input  logic                  inst_sram_addr_ok_i,
    input  logic                  inst_sram_data_ok_i,
    input  logic [INST_WIDTH-1:0] inst_sram_rdata_i,
    output logic                  inst_valid_o,
    output logic [PC_WIDTH-1:0]   inst_pc_o,
    output logic [INST_WIDTH-1:0] inst_o,
    input  logic                  inst_ready_i
);
    localparam int AW = $clog2(OST_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(OST_DEPTH);
    typedef enum logic {IDLE, REQ} state_e;
    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                  flush_seen_q, flush_seen_d;
    logic [AW-1:0]         head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [AW:0]           count_q, count_d;
    logic [PC_WIDTH-1:0]   pc_q [OST_DEPTH];
    logic [PC_WIDTH-1:0]   pc_d [OST_DEPTH];
    logic [INST_WIDTH-1:0] inst_q [OST_DEPTH];
    logic [INST_WIDTH-1:0] inst_d [OST_DEPTH];
    logic [OST_DEPTH-1:0]  valid_q, valid_d, done_q, done_d, cancel_q, cancel_d;
    logic                  push, pop, data_avail, head_cmpl, byp, fire;
    assign data_avail = valid_q[fill_q] && !done_q[fill_q];
    assign head_cmpl  = inst_sram_data_ok_i && data_avail && fill_q == head_q;
`ifdef IFETCH_DATA_BYPASS_EN
    assign byp = head_cmpl;
`else
    assign byp = 1'b0;
`endif
    assign push             = state_q == REQ && inst_sram_addr_ok_i;
    assign pc_ready_o       = state_q == IDLE && !flush_i && count_q < FULL;
    assign inst_sram_req_o  = state_q == REQ;
    assign inst_sram_addr_o = req_pc_q;
    assign inst_valid_o     = valid_q[head_q] && (done_q[head_q] || byp) && !cancel_q[head_q] && !flush_i;
    assign inst_pc_o        = pc_q[head_q];
    assign inst_o           = byp ? inst_sram_rdata_i : inst_q[head_q];
    assign fire             = inst_valid_o && inst_ready_i;
    // a cancelled head completing this cycle is dropped without waiting for a stored copy
    assign pop = valid_q[head_q] && (done_q[head_q] ? (cancel_q[head_q] || flush_i || fire)
                                                    : head_cmpl && (cancel_q[head_q] || fire));
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        flush_seen_d = flush_seen_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_d       = fill_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        valid_d      = valid_q;
        done_d       = done_q;
        cancel_d     = cancel_q | (valid_q & {OST_DEPTH{flush_i}});
        if (pc_valid_i && pc_ready_o) begin
            state_d  = REQ;
            req_pc_d = pc_i;
        end
        if (state_q == REQ) begin
            flush_seen_d = inst_sram_addr_ok_i ? 1'b0 : flush_seen_q || flush_i;
            state_d      = inst_sram_addr_ok_i ? IDLE : REQ;
        end
        if (inst_sram_data_ok_i && data_avail) begin
            done_d[fill_q] = 1'b1;
            inst_d[fill_q] = inst_sram_rdata_i;
            fill_d         = fill_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q]  = 1'b0;
            done_d[head_q]   = 1'b0;
            cancel_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q]  = 1'b1;
            done_d[tail_q]   = 1'b0;
            cancel_d[tail_q] = flush_i || flush_seen_q;
            pc_d[tail_q]     = req_pc_q;
            tail_d           = tail_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_pc_q     <= '0;
            flush_seen_q <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            count_q      <= '0;
            pc_q         <= '{default: '0};
            inst_q       <= '{default: '0};
            valid_q      <= '0;
            done_q       <= '0;
            cancel_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            flush_seen_q <= flush_seen_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_q       <= fill_d;
            count_q      <= count_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            cancel_q     <= cancel_d;
        end
    end
    spurious_data_ok: assert property (@(posedge clk) disable iff (rst) inst_sram_data_ok_i |-> data_avail);
endmodule

// File: tb/tb_ifetch_req_ctrl.sv
// tb_ifetch_req_ctrl: directed checks of fetch issue, back-pressure, flush cancel and async reset
module tb_ifetch_req_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_valid_i, flush_i, inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_ready_i;
    logic [31:0] pc_i, inst_sram_rdata_i;
    logic        pc_ready_o, inst_sram_req_o, inst_valid_o;
    logic [31:0] inst_sram_addr_o, inst_pc_o, inst_o;
    int          npass = 0;
    int          ntot = 0;

    ifetch_req_ctrl #(.PC_WIDTH(32), .INST_WIDTH(32), .OST_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i),
        .inst_sram_req_o(inst_sram_req_o), .inst_sram_addr_o(inst_sram_addr_o),
        .inst_sram_addr_ok_i(inst_sram_addr_ok_i), .inst_sram_data_ok_i(inst_sram_data_ok_i),
        .inst_sram_rdata_i(inst_sram_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o), .inst_o(inst_o),
        .inst_ready_i(inst_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pc_valid_i = 0; pc_i = 0; flush_i = 0; inst_sram_addr_ok_i = 0;
        inst_sram_data_ok_i = 0; inst_sram_rdata_i = 0; inst_ready_i = 1;
        cyc(); cyc();
        chk("rst_req", inst_sram_req_o, 0);
        chk("rst_addr", inst_sram_addr_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_inst", inst_o, 0);
        rst = 0;
        cyc();
        chk("rst_pc_ready", pc_ready_o, 1);

        // single fetch: T
        pc_valid_i = 1; pc_i = 32'h1c000000; #1;
        chk("t1_ready_T", pc_ready_o, 1);
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        chk("t1_req_T1", inst_sram_req_o, 1);
        chk("t1_addr_T1", inst_sram_addr_o, 32'h1c000000);
        chk("t1_ready_T1", pc_ready_o, 0);
        cyc(); inst_sram_addr_ok_i = 0; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h02800000; #1;
        chk("t1_req_T2", inst_sram_req_o, 0);
        chk("t1_ready_T2", pc_ready_o, 1);
`ifdef IFETCH_DATA_BYPASS_EN
        chk("t1_valid_T2", inst_valid_o, 1);
        chk("t1_inst_T2", inst_o, 32'h02800000);
        chk("t1_pc_T2", inst_pc_o, 32'h1c000000);
        cyc(); inst_sram_data_ok_i = 0; #1;
        chk("t1_valid_T3", inst_valid_o, 0);
`else
        chk("t1_valid_T2", inst_valid_o, 0);
        cyc(); inst_sram_data_ok_i = 0; #1;
        chk("t1_valid_T3", inst_valid_o, 1);
        chk("t1_pc_T3", inst_pc_o, 32'h1c000000);
        chk("t1_inst_T3", inst_o, 32'h02800000);
        cyc(); #1;
        chk("t1_valid_T4", inst_valid_o, 0);
`endif

        // back-pressure
        cyc(); inst_ready_i = 0; pc_valid_i = 1; pc_i = 32'h1c000004; #1;
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        cyc(); inst_sram_addr_ok_i = 0; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'haaaa0001;
        pc_valid_i = 1; pc_i = 32'h1c000008; #1;
        chk("bp_ready_second", pc_ready_o, 1);
        cyc(); inst_sram_data_ok_i = 0; pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        chk("bp_valid_a", inst_valid_o, 1);
        chk("bp_addr_b", inst_sram_addr_o, 32'h1c000008);
        cyc(); inst_sram_addr_ok_i = 0; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'haaaa0002;
        pc_valid_i = 1; pc_i = 32'h1c00000c; #1;
        chk("bp_full", pc_ready_o, 0);
        cyc(); inst_sram_data_ok_i = 0; inst_ready_i = 1; #1;
        chk("bp_full_pop", pc_ready_o, 0);
        chk("bp_pc_a", inst_pc_o, 32'h1c000004);
        chk("bp_inst_a", inst_o, 32'haaaa0001);
        cyc(); pc_valid_i = 0; #1;
        chk("bp_ready_after", pc_ready_o, 1);
        chk("bp_valid_b", inst_valid_o, 1);
        chk("bp_pc_b", inst_pc_o, 32'h1c000008);
        chk("bp_inst_b", inst_o, 32'haaaa0002);
        cyc(); #1;
        chk("bp_empty", inst_valid_o, 0);

        // flush with two outstanding
        pc_valid_i = 1; pc_i = 32'h1c000010; #1;
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        cyc(); inst_sram_addr_ok_i = 0; pc_valid_i = 1; pc_i = 32'h1c000014; #1;
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        cyc(); inst_sram_addr_ok_i = 0; flush_i = 1; #1;
        chk("fl_ready_T", pc_ready_o, 0);
        cyc(); flush_i = 0; #1;
        chk("fl_ready_T1", pc_ready_o, 0);
        cyc(); inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'hbbbb0001; #1;
        chk("fl_valid_T2", inst_valid_o, 0);
        cyc(); inst_sram_rdata_i = 32'hbbbb0002; #1;
        chk("fl_valid_T3", inst_valid_o, 0);
        cyc(); inst_sram_data_ok_i = 0; #1;
        chk("fl_valid_T4", inst_valid_o, 0);
        chk("fl_count_T4", dut.count_q, 0);

        // flush while request waits for addr_ok
        pc_valid_i = 1; pc_i = 32'h1c000020; #1;
        cyc(); pc_valid_i = 0; flush_i = 1; #1;
        chk("fr_req_f1", inst_sram_req_o, 1);
        chk("fr_addr_f1", inst_sram_addr_o, 32'h1c000020);
        cyc(); flush_i = 0; #1;
        chk("fr_req_f2", inst_sram_req_o, 1);
        cyc(); #1;
        chk("fr_addr_f3", inst_sram_addr_o, 32'h1c000020);
        cyc(); inst_sram_addr_ok_i = 1; #1;
        chk("fr_req_f4", inst_sram_req_o, 1);
        cyc(); inst_sram_addr_ok_i = 0; #1;
        chk("fr_req_f5", inst_sram_req_o, 0);
        cyc(); inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'hcccc0001; #1;
        chk("fr_valid_f6", inst_valid_o, 0);
        cyc(); inst_sram_data_ok_i = 0; #1;
        chk("fr_valid_f7", inst_valid_o, 0);
        chk("fr_count_f7", dut.count_q, 0);

        // flush coincident with output handshake
        pc_valid_i = 1; pc_i = 32'h1c000030; #1;
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        cyc(); inst_sram_addr_ok_i = 0; inst_ready_i = 0; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'hdddd0001; #1;
        cyc(); inst_sram_data_ok_i = 0; #1;
        chk("fh_valid_pre", inst_valid_o, 1);
        inst_ready_i = 1; flush_i = 1; #1;
        chk("fh_valid_void", inst_valid_o, 0);
        cyc(); flush_i = 0; #1;
        chk("fh_valid_after", inst_valid_o, 0);
        chk("fh_count", dut.count_q, 0);

        // async reset with two entries in flight
        pc_valid_i = 1; pc_i = 32'h1c000040; #1;
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        cyc(); inst_sram_addr_ok_i = 0; pc_valid_i = 1; pc_i = 32'h1c000044; #1;
        cyc(); pc_valid_i = 0; inst_sram_addr_ok_i = 1; #1;
        cyc(); inst_sram_addr_ok_i = 0; inst_ready_i = 0; inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'heeee0001; #1;
        cyc(); inst_sram_data_ok_i = 0; #1;
        chk("ar_valid_pre", inst_valid_o, 1);
        chk("ar_pc_pre", inst_pc_o, 32'h1c000040);
        chk("ar_ready_pre", pc_ready_o, 0);
        rst = 1; #1;
        chk("ar_valid", inst_valid_o, 0);
        chk("ar_pc", inst_pc_o, 0);
        chk("ar_inst", inst_o, 0);
        chk("ar_req", inst_sram_req_o, 0);
        chk("ar_addr", inst_sram_addr_o, 0);
        cyc(); rst = 0; #1;
        cyc(); #1;
        chk("ar_ready_post", pc_ready_o, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/ifetch_req_ctrl.md
# ifetch_req_ctrl

Fetch-side request controller between the pre-IF PC generator and the instruction SRAM-like port (req/addr_ok/data_ok). It issues fetch requests and tracks up to `OST_DEPTH` outstanding requests in order. It cancels in-flight requests on flush by discarding their late `data_ok` beats, and buffers returned instructions until the IF/ID side accepts them. It replaces the ad-hoc one-deep cancel flag and one-entry rdata buffer with a single sequenced structure.

## Interface
Parameters:
- `PC_WIDTH`, 32, fetch address width
- `INST_WIDTH`, 32, instruction width
- `OST_DEPTH`, 2, maximum outstanding plus buffered fetches; power of two, at least 2

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc_valid_i`  in  1  pre-IF has a fetch PC
- `pc_i`  in  PC_WIDTH  fetch PC
- `pc_ready_o`  out  1  PC accepted this cycle when `pc_valid_i && pc_ready_o`
- `flush_i`  in  1  exception or branch flush, single-cycle pulse or level
- `inst_sram_req_o`  out  1  request to instruction SRAM
- `inst_sram_addr_o`  out  PC_WIDTH  request address
- `inst_sram_addr_ok_i`  in  1  request accepted
- `inst_sram_data_ok_i`  in  1  oldest accepted request returns data
- `inst_sram_rdata_i`  in  INST_WIDTH  returned instruction
- `inst_valid_o`  out  1  instruction available to IF/ID
- `inst_pc_o`  out  PC_WIDTH  PC of the presented instruction
- `inst_o`  out  INST_WIDTH  presented instruction
- `inst_ready_i`  in  1  IF/ID consumes when `inst_valid_o && inst_ready_i`

## Operation
- Request register (REQ state):
  - IDLE: `pc_ready_o = !flush_i && (count + 1 < OST_DEPTH + 1)`, i.e. `count < OST_DEPTH`.
  - On accept, latch `pc_i` into `req_pc` and go to REQ.
  - REQ: `inst_sram_req_o = 1` and `inst_sram_addr_o = req_pc`, both held stable until `inst_sram_addr_ok_i`.
  - The request is never withdrawn, not even on flush.
  - On `addr_ok`, go back to IDLE.
- Tracking FIFO: `OST_DEPTH` entries of {pc, inst, done, cancel}, with head, tail, data-fill pointer and `count`.
  - `addr_ok`: push {req_pc, done=0, cancel=flush_i || flush_seen_in_REQ}.
  - `flush_seen_in_REQ` is set by `flush_i` in REQ and cleared on `addr_ok`.
  - `data_ok`: write rdata into the oldest not-done entry and set `done`.
  - A `data_ok` with no outstanding entry is ignored. It must not occur; flag it as an assertion.
  - `flush_i`: set `cancel` on every valid entry in the same edge.
  - Head pop: head is done and (cancel, or the output handshake fires). At most one pop per cycle.
- Output: `inst_valid_o = head.done && !head.cancel && !flush_i`, with `inst_pc_o = head.pc` and `inst_o = head.inst`.
- Cancelled entries still occupy slots until their `data_ok` returns and they pop. New fetches after a flush therefore stall while `count == OST_DEPTH`.
- `count` updates by +1 on push and −1 on pop; simultaneous push and pop leaves it unchanged. Pointers wrap modulo `OST_DEPTH`.
- Reset: state IDLE, `count=0`, all pointers 0, all entries invalid. Outputs after reset: `pc_ready_o=1` (absent flush), `inst_sram_req_o=0`, `inst_sram_addr_o=0`, `inst_valid_o=0`, `inst_pc_o=0`, `inst_o=0`.

## Timing
- PC accepted at cycle T.
- `req_o` is high from T+1.
- With `addr_ok` at T+1, `data_ok` comes at T+2 at the earliest.
- `inst_valid_o` rises at T+3 (registered path).
- Full: `count == OST_DEPTH` forces `pc_ready_o=0`. A pop in that same cycle does not re-enable it until the next cycle.
- Flush in the accept cycle: no accept.
- Flush in the same cycle as `data_ok`: the entry is stored cancelled.
- Flush in the same cycle as an output handshake: the handshake is void and the entry becomes cancelled and pops.
- Flush in the same cycle as `addr_ok`: the pushed entry is cancelled.
- Reset mid-operation clears everything immediately. Any late `data_ok` after reset is the SRAM's responsibility.

## Configuration
- `IFETCH_DATA_BYPASS_EN` defined:
  - When `data_ok` completes the head entry and it is not cancelled, `inst_valid_o` asserts in the `data_ok` cycle with `inst_o = inst_sram_rdata_i`.
  - If consumed, the entry pops that edge without storing.
  - Minimum latency becomes T+2.
- `IFETCH_DATA_BYPASS_EN` undefined: registered output only, as above.

## Test plan
- Single fetch: `pc_i=0x1c000000`, `addr_ok` at T+1, `data_ok` at T+2 with rdata `0x02800000` -> `inst_valid_o` at T+3 with pc `0x1c000000`; at T+2 when `IFETCH_DATA_BYPASS_EN` is defined.
- Back-pressure: `inst_ready_i=0`, 2 fetches returned -> `count=2`, `pc_ready_o=0`; raise ready -> pcs in order, `pc_ready_o=1` one cycle after the first pop.
- Flush with 2 outstanding: flush at T, then `data_ok` at T+2 and T+3 -> `inst_valid_o` stays 0 and `count` reaches 0 at T+4.
- Flush while REQ holds without `addr_ok`: `req_o` and addr stay stable; `addr_ok` 3 cycles later pushes a cancelled entry, whose data is discarded.
- Flush coincident with output handshake -> no consumption reported and the entry is popped as cancelled.
- `rst` asserted with 2 entries in flight -> all outputs 0 asynchronously and `pc_ready_o=1` after release.
